// File: rtl/wr_burst_writer_pkg.sv
// wr_burst_writer_pkg: shared FSM state type, settle default and free-space helper for the FIFO write side.
package wr_burst_writer_pkg;
  localparam int SETTLE_DEF = 2;
  typedef enum logic [2:0] {IDLE, WAIT_ROOM, BURST, DONE, ERR} wb_state_e;
  // A full FIFO reports usedw==0, so full must override the subtraction.
  function automatic int unsigned free_words(input logic full, input int unsigned usedw, input int unsigned depth);
    return full ? 32'd0 : depth - usedw;
  endfunction
endpackage

// File: rtl/wr_burst_writer_if.sv
// wr_burst_writer_if: command, source and FIFO-write signals of the burst writer.
interface wr_burst_writer_if #(parameter int DWIDTH = 8, parameter int AWIDTH = 4);
  logic              cmd_valid_i;
  logic [AWIDTH:0]   cmd_len_i;
  logic              cmd_ready_o;
  logic [DWIDTH-1:0] src_data_i;
  logic              src_valid_i;
  logic              src_ready_o;
  logic              wr_full_i;
  logic [AWIDTH-1:0] wr_usedw_i;
  logic              wr_req_o;
  logic [DWIDTH-1:0] wr_data_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  modport master (
    output cmd_valid_i, cmd_len_i, src_data_i, src_valid_i, wr_full_i, wr_usedw_i,
    input  cmd_ready_o, src_ready_o, wr_req_o, wr_data_o, busy_o, done_o, err_o
  );
  modport slave (
    input  cmd_valid_i, cmd_len_i, src_data_i, src_valid_i, wr_full_i, wr_usedw_i,
    output cmd_ready_o, src_ready_o, wr_req_o, wr_data_o, busy_o, done_o, err_o
  );
endinterface

// File: rtl/wr_burst_writer.sv
// wr_burst_writer: waits for FIFO room, then streams a commanded burst of source words into the FIFO.
module wr_burst_writer
  import wr_burst_writer_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4,
  parameter int SETTLE = SETTLE_DEF
) (
  input logic wr_clk_i,
  input logic sclr_i,
  wr_burst_writer_if.slave bus
);
  localparam int unsigned DEPTH = 1 << AWIDTH;
  localparam int SW = $clog2(SETTLE + 2);
  wb_state_e state;
  logic [AWIDTH:0] len, cnt, cnt_nxt;
  logic [SW-1:0] settle;
  logic [DWIDTH-1:0] data;
  logic cmd_ready, busy, done, err, src_ready, wr_req, room_ok;
  assign cnt_nxt = cnt + (AWIDTH+1)'(1);
  assign room_ok = free_words(bus.wr_full_i, 32'(bus.wr_usedw_i), DEPTH) >= 32'(len);
  // Reset gates the write path combinationally so a reset cycle never writes.
  assign src_ready = sclr_i && state == BURST && !bus.wr_full_i;
  assign wr_req = src_ready && bus.src_valid_i;
  assign data = bus.src_data_i;
  assign bus.wr_data_o = data;
  assign bus.src_ready_o = src_ready;
  assign bus.wr_req_o = wr_req;
  assign bus.cmd_ready_o = cmd_ready;
  assign bus.busy_o = busy;
  assign bus.done_o = done;
  assign bus.err_o = err;
  always_ff @(posedge wr_clk_i) begin
    if (!sclr_i) begin
      state <= IDLE;
      len <= '0;
      cnt <= '0;
      settle <= '0;
      cmd_ready <= 1'b1;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (bus.cmd_valid_i && cmd_ready) begin
          len <= bus.cmd_len_i;
          cnt <= '0;
          settle <= '0;
          cmd_ready <= 1'b0;
          busy <= 1'b1;
          if (bus.cmd_len_i == '0) begin
            state <= DONE;
            done <= 1'b1;
          end else if (32'(bus.cmd_len_i) > DEPTH) begin
            state <= ERR;
            err <= 1'b1;
          end else state <= WAIT_ROOM;
        end
        // usedw lags the last write by the pointer and usedw registers; wait it out.
        WAIT_ROOM: if (settle != SW'(SETTLE)) settle <= settle + SW'(1);
          else if (room_ok) state <= BURST;
        BURST: if (wr_req) begin
          cnt <= cnt_nxt;
          if (cnt_nxt == len) begin
            state <= DONE;
            done <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cmd_ready <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/wr_burst_writer.md
Name: wr_burst_writer

Overview:
- Write-domain producer sitting directly upstream of the async FIFO write-pointer/full logic.
- Accepts burst commands (word count), waits until the FIFO reports enough free space, then streams that many words from a valid/ready source into the FIFO via wr_req.
- Uses the FIFO's registered wr_full and wr_usedw feedback and compensates for their latency, so a burst never stalls on full once started (absent faults).

Parameters:
- DWIDTH, 8, data word width.
- AWIDTH, 4, FIFO address width; depth = 2**AWIDTH words.
- SETTLE, 2, cycles held in WAIT_ROOM before free space is trusted (covers pointer register plus usedw register latency).

Ports:
- wr_clk_i  in  1  write-domain clock.
- sclr_i  in  1  reset: synchronous, active-low.
- cmd_valid_i  in  1  burst command valid.
- cmd_len_i  in  AWIDTH+1  burst length in words; legal range 0..2**AWIDTH.
- cmd_ready_o  out  1  command accepted when cmd_valid_i & cmd_ready_o.
- src_data_i  in  DWIDTH  source data.
- src_valid_i  in  1  source word valid.
- src_ready_o  out  1  source word consumed when src_valid_i & src_ready_o.
- wr_full_i  in  1  FIFO full (registered, from write-pointer block).
- wr_usedw_i  in  AWIDTH  FIFO used words (registered; reads 0 when full).
- wr_req_o  out  1  FIFO write request.
- wr_data_o  out  DWIDTH  FIFO write data.
- busy_o  out  1  high in any state except IDLE.
- done_o  out  1  one-cycle pulse: burst complete.
- err_o  out  1  one-cycle pulse: illegal length rejected.

Behaviour:
- FSM states: IDLE, WAIT_ROOM, BURST, DONE, ERR.
- Reset: sclr_i low at a rising edge forces IDLE and clears all counters and registered outputs. Reset mid-burst abandons the burst with no done_o.
  - wr_req_o and src_ready_o are additionally gated by sclr_i combinationally, so no write occurs during a reset cycle.
- Reset values: cmd_ready_o=1 (IDLE), src_ready_o=0, wr_req_o=0, busy_o=0, done_o=0, err_o=0.
- IDLE: cmd_ready_o=1. On handshake, latch len.
  - len==0 -> DONE.
  - len>2**AWIDTH -> ERR.
  - Otherwise -> WAIT_ROOM with settle counter=0.
- WAIT_ROOM:
  - Settle counter increments to SETTLE; no comparison before that.
  - Then each cycle compute free = wr_full_i ? 0 : 2**AWIDTH - wr_usedw_i, in AWIDTH+2 bits. usedw==0 and !full means free=2**AWIDTH.
  - free >= len -> BURST next cycle; otherwise stay.
- BURST:
  - src_ready_o = !wr_full_i.
  - wr_req_o = src_valid_i & !wr_full_i.
  - wr_data_o = src_data_i, combinational pass-through.
  - Word counter increments per write. The write that makes count==len -> DONE.
  - If wr_full_i rises mid-burst (stale reader view), hold with no write; resume when it drops.
- DONE: done_o=1 for exactly one cycle -> IDLE.
- ERR: err_o=1 for exactly one cycle -> IDLE; no writes issued.
- Outside BURST: wr_req_o=0, src_ready_o=0, wr_data_o=src_data_i (don't-care).
- Back-to-back commands:
  - Command accepted on the cycle after DONE.
  - The following WAIT_ROOM settle guarantees wr_usedw_i reflects the previous burst's final write.
- Latency:
  - Command handshake to first possible wr_req_o: SETTLE+2 cycles.
  - Last write to done_o: 1 cycle.

Decomposition:
- Shared FIFO package: state enum type and the SETTLE default constant.
- Single module; no sub-module needed. The free-space calculation is a small function in the package.

Test Plan (AWIDTH=4, DWIDTH=8):
1. Reset, empty FIFO (usedw=0, full=0), cmd_len=16, source always valid with data 0..15 -> first wr_req 4 cycles after command; 16 consecutive writes of 0..15; done_o pulses 1 cycle after the 16th write; no write while full.
2. usedw=12, cmd_len=5 -> stays in WAIT_ROOM with no wr_req. Drive usedw=11 -> BURST starts; exactly 5 writes.
3. cmd_len=0 -> done_o 1 cycle after handshake, zero writes. cmd_len=17 -> err_o pulse, zero writes, busy_o back low the next cycle.
4. cmd_len=8, src_valid toggles 1,0,1,0 -> 8 writes spread over 16 cycles; wr_data matches the source word on each write.
5. Mid-burst: force wr_full_i=1 for 3 cycles -> wr_req_o and src_ready_o low those cycles; burst completes with the correct count afterwards.
6. sclr_i low after 3 of 10 writes -> no wr_req in the reset cycle, IDLE next cycle, no done_o; a new cmd_len=2 then completes normally.
